// File: rtl/vid_tx_pkg.sv
// Shared types and sizing helpers for the video output transmitter.
package vid_tx_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitSof = 2'd1,
        StRun     = 2'd2
    } tx_state_e;

    function automatic int unsigned calc_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Raster position counters plus combinational region flags for the current position.
module vid_timing_cnt
    import vid_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 2560,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_BP     = 80,
    parameter int unsigned V_ACTIVE = 1440,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HW       = cnt_width(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int unsigned VW       = cnt_width(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_run,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_first
);

    localparam int unsigned H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_BEG   = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG   = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [31:0]   w_h_ext;
    logic [31:0]   w_v_ext;

    // Counters sit at the origin whenever timing is not running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign w_h_ext = 32'(r_h_cnt);
    assign w_v_ext = 32'(r_v_cnt);

    assign o_h_cnt  = r_h_cnt;
    assign o_v_cnt  = r_v_cnt;
    assign o_active = (w_h_ext < H_ACTIVE) && (w_v_ext < V_ACTIVE);
    assign o_hsync  = (w_h_ext >= HS_BEG) && (w_h_ext < HS_END);
    assign o_vsync  = (w_v_ext >= VS_BEG) && (w_v_ext < VS_END);
    assign o_first  = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/vid_out_tx.sv
// Video output transmitter: frames an SOF-marked pixel stream onto raster timing,
// with registered sync/DE/RGB outputs and sticky underflow / SOF-alignment flags.
module vid_out_tx
    import vid_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 2560,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_BP     = 80,
    parameter int unsigned V_ACTIVE = 1440,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        pix_clk,
    input  logic        sys_rst_n,
    input  logic        en,
    input  logic        clr_err,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic [23:0] hdmi_RGB_data_o,
    output logic        hdmi_hsync_o,
    output logic        hdmi_vsync_o,
    output logic        hdmi_pix_en_o,
    output logic        frame_start,
    output logic        underflow_err,
    output logic        sync_err
);

    localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = cnt_width(H_TOTAL);
    localparam int unsigned VW      = cnt_width(V_TOTAL);

    tx_state_e     r_state;
    tx_state_e     w_state_next;
    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_active;
    logic          w_hs_region;
    logic          w_vs_region;
    logic          w_first;
    logic          w_run;
    logic          w_sof_origin;
    logic          w_late_sof;
    logic          w_early_sof;
    logic          w_ready;
    logic          w_take;
    logic          w_uf_set;
    logic          w_se_set;

    logic [23:0]   r_rgb;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_pix_en;
    logic          r_frame_start;
    logic          r_underflow;
    logic          r_sync_err;

    assign w_run = en && (r_state != StIdle);

    vid_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .i_clk    (pix_clk),
        .i_rst_n  (sys_rst_n),
        .i_run    (w_run),
        .o_h_cnt  (w_h_cnt),
        .o_v_cnt  (w_v_cnt),
        .o_active (w_active),
        .o_hsync  (w_hs_region),
        .o_vsync  (w_vs_region),
        .o_first  (w_first)
    );

    assign w_sof_origin = w_first && pix_valid && pix_sof;
    assign w_late_sof   = w_first && pix_valid && !pix_sof;
    assign w_early_sof  = w_active && !w_first && pix_valid && pix_sof;

    always_ff @(posedge pix_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle:    w_state_next = StWaitSof;
                StWaitSof: if (w_sof_origin) w_state_next = StRun;
                StRun:     if (w_late_sof || w_early_sof) w_state_next = StWaitSof;
                default:   w_state_next = StIdle;
            endcase
        end
    end

    // w_take: the pixel at the head is accepted and shown on the next cycle.
    always_comb begin
        w_ready  = 1'b0;
        w_take   = 1'b0;
        w_uf_set = 1'b0;
        w_se_set = 1'b0;
        if (en) begin
            case (r_state)
                StWaitSof: begin
                    // Flush anything that is not an SOF; hold an SOF until the origin.
                    w_ready = pix_valid && (!pix_sof || w_first);
                    w_take  = w_sof_origin;
                end
                StRun: begin
                    w_ready = w_active && !w_early_sof;
                    if (w_active) begin
                        if (!pix_valid) begin
                            w_uf_set = 1'b1;
                        end else if (w_late_sof || w_early_sof) begin
                            w_se_set = 1'b1;
                        end else begin
                            w_take = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pix_ready = w_ready;

    always_ff @(posedge pix_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rgb         <= '0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_pix_en      <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!w_run) begin
            r_rgb         <= '0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_pix_en      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_take ? pix_data : 24'h0;
            r_hsync       <= w_hs_region ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_region ? VS_POL : ~VS_POL;
            r_pix_en      <= w_active;
            r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
        end
    end

    // A new event in the same cycle takes priority over the clear.
    always_ff @(posedge pix_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_underflow <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_underflow <= w_uf_set | (r_underflow & ~clr_err);
            r_sync_err  <= w_se_set | (r_sync_err & ~clr_err);
        end
    end

    assign hdmi_RGB_data_o = r_rgb;
    assign hdmi_hsync_o    = r_hsync;
    assign hdmi_vsync_o    = r_vsync;
    assign hdmi_pix_en_o   = r_pix_en;
    assign frame_start     = r_frame_start;
    assign underflow_err   = r_underflow;
    assign sync_err        = r_sync_err;

endmodule

// File: tb/tb_vid_out_tx.sv
// Directed bench for vid_out_tx with a frame-position model checked every cycle.
module tb_vid_out_tx;

    localparam int HA = 8;
    localparam int HT = 14;
    localparam int VA = 4;
    localparam int FT = 98;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b0;

    logic        pix_clk = 1'b0;
    logic        sys_rst_n;
    logic        en;
    logic        clr_err;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [23:0] hdmi_RGB_data_o;
    logic        hdmi_hsync_o;
    logic        hdmi_vsync_o;
    logic        hdmi_pix_en_o;
    logic        frame_start;
    logic        underflow_err;
    logic        sync_err;

    vid_out_tx #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (2),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) dut (
        .pix_clk         (pix_clk),
        .sys_rst_n       (sys_rst_n),
        .en              (en),
        .clr_err         (clr_err),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_sof         (pix_sof),
        .pix_ready       (pix_ready),
        .hdmi_RGB_data_o (hdmi_RGB_data_o),
        .hdmi_hsync_o    (hdmi_hsync_o),
        .hdmi_vsync_o    (hdmi_vsync_o),
        .hdmi_pix_en_o   (hdmi_pix_en_o),
        .frame_start     (frame_start),
        .underflow_err   (underflow_err),
        .sync_err        (sync_err)
    );

    always #5 pix_clk = ~pix_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 = disabled, 1 = hunting for SOF, 2 = locked; m_t = position in frame.
    int m_mode = 0;
    int m_t    = 0;
    logic [23:0] e_rgb;
    logic e_pe, e_hs, e_vs, e_fs, e_uf, e_se;

    // Source: optional prefix queue, then an endless stream where every 32nd pixel is SOF.
    logic [24:0] pre_q[$];
    int src_k = 0;
    bit stream_on = 0;
    bit gap_on = 0;

    bit count_on = 0;
    int cnt_hs = 0, cnt_vs_low = 0, cnt_pe = 0, cnt_rgb_nz = 0;
    logic [23:0] inj_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_reset_exp();
        e_rgb = '0;
        e_pe  = 1'b0;
        e_hs  = ~HS_POL;
        e_vs  = ~VS_POL;
        e_fs  = 1'b0;
        e_uf  = 1'b0;
        e_se  = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_rgb"}, hdmi_RGB_data_o, 24'h0);
        check({tag, "_pix_en"}, hdmi_pix_en_o, 1'b0);
        check({tag, "_hsync"}, hdmi_hsync_o, 1'b0);
        check({tag, "_vsync"}, hdmi_vsync_o, 1'b1);
        check({tag, "_frame_start"}, frame_start, 1'b0);
        check({tag, "_underflow"}, underflow_err, 1'b0);
        check({tag, "_sync_err"}, sync_err, 1'b0);
        check({tag, "_ready"}, pix_ready, 1'b0);
    endtask

    task automatic drive();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = '0;
        if (gap_on) begin
            pix_valid = 1'b0;
        end else if (pre_q.size() > 0) begin
            {pix_sof, pix_data} = pre_q[0];
            pix_valid = 1'b1;
        end else if (stream_on) begin
            pix_data  = 24'(src_k + 1);
            pix_sof   = (src_k % 32) == 0;
            pix_valid = 1'b1;
        end
    endtask

    task automatic step();
        int h, v;
        bit act, first, rdy, take, uf, se;
        logic [23:0] n_rgb;
        logic n_pe, n_hs, n_vs, n_fs, n_uf, n_se;
        @(negedge pix_clk);
        drive();
        #1;
        rdy = 0; take = 0; uf = 0; se = 0;
        n_rgb = '0; n_pe = 1'b0; n_hs = ~HS_POL; n_vs = ~VS_POL; n_fs = 1'b0;
        h = m_t % HT;
        v = m_t / HT;
        act = (h < HA) && (v < VA);
        first = (m_t == 0);
        if (m_mode != 0 && en) begin
            if (m_mode == 1) begin
                rdy  = pix_valid && (!pix_sof || first);
                take = first && pix_valid && pix_sof;
            end else begin
                rdy = act && !(pix_valid && pix_sof && !first);
                if (act) begin
                    if (!pix_valid) uf = 1;
                    else if ((first && !pix_sof) || (!first && pix_sof)) se = 1;
                    else take = 1;
                end
            end
            n_rgb = take ? pix_data : 24'h0;
            n_pe  = act;
            n_hs  = (h >= HA + 2 && h < HA + 4) ? HS_POL : ~HS_POL;
            n_vs  = (v == VA + 1) ? VS_POL : ~VS_POL;
            n_fs  = first;
        end
        n_uf = uf | (e_uf & ~clr_err);
        n_se = se | (e_se & ~clr_err);
        check("pix_ready", pix_ready, rdy);
        if (pix_valid && rdy) begin
            if (pre_q.size() > 0) void'(pre_q.pop_front());
            else src_k++;
        end
        if (gap_on && m_mode == 2 && en && act) src_k++;
        if (!en) begin
            m_mode = 0;
            m_t = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_t = 0;
        end else begin
            if (m_mode == 1 && take) m_mode = 2;
            else if (m_mode == 2 && se) m_mode = 1;
            m_t = (m_t + 1) % FT;
        end
        @(posedge pix_clk);
        #1;
        e_rgb = n_rgb; e_pe = n_pe; e_hs = n_hs; e_vs = n_vs; e_fs = n_fs;
        e_uf = n_uf; e_se = n_se;
        check("rgb", hdmi_RGB_data_o, e_rgb);
        check("pix_en", hdmi_pix_en_o, e_pe);
        check("hsync", hdmi_hsync_o, e_hs);
        check("vsync", hdmi_vsync_o, e_vs);
        check("frame_start", frame_start, e_fs);
        check("underflow_err", underflow_err, e_uf);
        check("sync_err", sync_err, e_se);
        if (count_on) begin
            if (hdmi_hsync_o === 1'b1) cnt_hs++;
            if (hdmi_vsync_o === 1'b0) cnt_vs_low++;
            if (hdmi_pix_en_o === 1'b1) cnt_pe++;
            if (hdmi_RGB_data_o !== 24'h0) cnt_rgb_nz++;
        end
    endtask

    task automatic wait_pos(input int p, input int mode_req);
        int n = 0;
        while (!(m_t == p && m_mode == mode_req) && n < 300) begin
            step();
            n++;
        end
        check("wait_pos_reached", 32'(m_t == p && m_mode == mode_req), 1);
    endtask

    task automatic wait_fs();
        int n = 0;
        while (frame_start !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check("frame_start_seen", frame_start, 1'b1);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        en        = 1'b0;
        clr_err   = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = '0;
        set_reset_exp();
        #12;
        check_reset_outs("reset");
        @(negedge pix_clk);
        sys_rst_n = 1'b1;
        repeat (3) step();

        // Timing only, no source data.
        en = 1'b1;
        repeat (FT) step();
        count_on = 1;
        repeat (FT) step();
        count_on = 0;
        check("hsync_high_per_frame", cnt_hs, 14);
        check("vsync_low_per_frame", cnt_vs_low, 14);
        check("pix_en_per_frame", cnt_pe, 32);
        check("rgb_black_no_data", cnt_rgb_nz, 0);
        repeat (10) step();

        // Stale pixels ahead of the SOF, then a continuous stream.
        pre_q.push_back({1'b0, 24'hAA0001});
        pre_q.push_back({1'b0, 24'hAA0002});
        pre_q.push_back({1'b0, 24'hAA0003});
        src_k = 0;
        stream_on = 1;
        wait_fs();
        check("first_pixel", hdmi_RGB_data_o, 24'h000001);
        repeat (7) step();
        check("pixel_pos7", hdmi_RGB_data_o, 24'h000008);
        repeat (7) step();
        check("pixel_line1_pos0", hdmi_RGB_data_o, 24'h000009);
        repeat (2 * FT) step();
        check("stream_no_underflow", underflow_err, 1'b0);
        check("stream_no_sync_err", sync_err, 1'b0);

        // Three missing pixels mid-line; clr_err held over the event must lose.
        wait_pos(17, 2);
        gap_on = 1;
        clr_err = 1'b1;
        repeat (3) step();
        gap_on = 0;
        clr_err = 1'b0;
        check("gap_rgb_black", hdmi_RGB_data_o, 24'h0);
        check("gap_pix_en", hdmi_pix_en_o, 1'b1);
        check("underflow_set", underflow_err, 1'b1);
        repeat (FT) step();
        check("gap_no_sync_err", sync_err, 1'b0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("underflow_cleared", underflow_err, 1'b0);

        // SOF arriving early at active position 5.
        wait_pos(5, 2);
        src_k = ((src_k + 31) / 32) * 32;
        inj_val = 24'(src_k + 1);
        step();
        step();
        check("early_sof_sync_err", sync_err, 1'b1);
        check("early_sof_black", hdmi_RGB_data_o, 24'h0);
        wait_fs();
        check("early_sof_restart", hdmi_RGB_data_o, inj_val);

        // Asynchronous reset at h=4, v=2.
        wait_pos(32, 2);
        check("pre_reset_sync_err", sync_err, 1'b1);
        @(negedge pix_clk);
        drive();
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_reset_outs("async_reset");
        m_mode = 0;
        m_t = 0;
        set_reset_exp();
        @(posedge pix_clk);
        #1;
        check_reset_outs("reset_held");
        sys_rst_n = 1'b1;
        step();
        check("post_reset_idle_fs", frame_start, 1'b0);
        check("post_reset_idle_pe", hdmi_pix_en_o, 1'b0);
        step();
        check("post_reset_origin_fs", frame_start, 1'b1);
        check("post_reset_origin_pe", hdmi_pix_en_o, 1'b1);
        repeat (150) step();

        // Enable dropped mid-frame.
        wait_pos(40, 2);
        en = 1'b0;
        step();
        check("en_off_pix_en", hdmi_pix_en_o, 1'b0);
        check("en_off_vsync", hdmi_vsync_o, 1'b1);
        repeat (3) step();
        en = 1'b1;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vid_out_tx.md
VID_OUT_TX -- requirements
Module: vid_out_tx

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 2560 active pixels/line; H_FP 48; H_SYNC 32; H_BP 80; V_ACTIVE 1440 active lines; V_FP 3; V_SYNC 5; V_BP 33; HS_POL 1 hsync asserted level; VS_POL 0 vsync asserted level.
REQ-002 Ports (name, direction, width, meaning); one clock, reset asynchronous and active-low:
- pix_clk  in  1  pixel clock, sole clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- en  in  1  timing enable.
- clr_err  in  1  clears sticky flags.
- pix_data  in  24  RGB888 source pixel.
- pix_valid  in  1  source pixel valid.
- pix_sof  in  1  marks first pixel of a frame.
- pix_ready  out  1  pixel accepted this cycle when high with pix_valid.
- hdmi_RGB_data_o  out  24  output pixel.
- hdmi_hsync_o  out  1  horizontal sync.
- hdmi_vsync_o  out  1  vertical sync.
- hdmi_pix_en_o  out  1  data enable.
- frame_start  out  1  one-cycle pulse.
- underflow_err  out  1  sticky underflow flag.
- sync_err  out  1  sticky SOF misalignment flag.

Function
REQ-003 h_cnt counts 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP); v_cnt increments on h_cnt wrap and covers 0..V_TOTAL-1, both wrapping to 0; region order: active, front porch, sync, back porch.
REQ-004 Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync region: H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync region analogous on v_cnt, with level changes aligned to h_cnt==0.
REQ-005 All video outputs are registered with exactly 1 cycle latency from the counter state; sync outputs equal HS_POL/VS_POL inside sync regions and the inverse outside.
REQ-006 hdmi_pix_en_o is high for every active-region cycle whenever en=1, independent of data availability.
REQ-007 FSM states: IDLE, WAIT_SOF, RUN.
- IDLE: entered while en=0; counters held at 0; pix_ready=0; outputs at reset values. en=1 -> WAIT_SOF.
- WAIT_SOF: counters run; output RGB=0. pix_ready=1 when pix_valid and !pix_sof (drop stale pixels); pix_ready=0 when SOF is at the head. At h_cnt=0, v_cnt=0 with SOF at the head -> RUN, and that pixel is consumed in the same cycle.
- RUN: pix_ready = active and not (pix_valid and pix_sof and position not (0,0)).
REQ-008 In RUN at (0,0), pix_valid=1 with pix_sof=0 (late SOF): pixel dropped, RGB=0, sync_err set, -> WAIT_SOF.
REQ-009 In RUN, SOF at the head in active region other than (0,0) (early SOF): not consumed, RGB=0, sync_err set, -> WAIT_SOF.
REQ-010 In RUN, active cycle with pix_valid=0: RGB=0, pix_en still 1, underflow_err set, state unchanged; missing pixel is not retried.
REQ-011 Consumed pixels drive hdmi_RGB_data_o one cycle later; RGB=0 outside active region.
REQ-012 frame_start pulses high, aligned with output of position (0,0), each frame while en=1.
REQ-013 clr_err clears both sticky flags; a flag event in the same cycle wins over clr_err.
REQ-014 en deasserted mid-frame -> IDLE next cycle, counters reset to 0, outputs to reset values.

Reset
REQ-015 Reset is asynchronous and active-low: state IDLE, counters 0, pix_ready 0, RGB 0, pix_en 0, hsync=~HS_POL, vsync=~VS_POL, frame_start 0, both flags 0.
REQ-016 Reset asserted mid-frame takes effect immediately and discards any partial frame.

Structure
REQ-017 Package vid_tx_pkg holds the FSM state enum, the H_TOTAL/V_TOTAL derivation, and the counter width function (clog2 of total).
REQ-018 One sub-module, vid_timing_cnt, provides h_cnt/v_cnt, the active/hsync/vsync region flags and the first-pixel flag; the top holds the FSM, handshake and output registers.

Verification (bench parameters H 8/2/2/2, V 4/1/1/1, HS_POL=1, VS_POL=0)
REQ-019 en=1, no data -> hsync high 2 cycles every 14; vsync low for 14 cycles every 98; pix_en high 8 cycles on lines 0-3; RGB=0.
REQ-020 Continuous valid stream 0x000001.. with SOF on the first pixel -> RUN; pixel k appears at active position k; frame_start once per 98 cycles; no flags set.
REQ-021 pix_valid dropped for 3 active cycles mid-line -> 3 black pixels, pix_en=1, underflow_err=1; clr_err -> flag 0.
REQ-022 SOF presented at active position 5 -> not consumed, sync_err=1, black until next (0,0), then frame starts with that SOF pixel.
REQ-023 3 non-SOF pixels precede SOF in WAIT_SOF -> all 3 dropped (pix_ready=1), SOF pixel consumed at (0,0).
REQ-024 sys_rst_n pulsed low at h_cnt=4, v_cnt=2 -> all outputs at reset values asynchronously; after release, IDLE then WAIT_SOF with counters from 0.
